pmu: RTL and testbench

Parametrised program management unit for the Baej core, the next generation of the program-management block. It owns the PC and a return-address stack (RAS) of configurable depth, and runs a handshaked instruction-fetch FSM. Each fetch reads one instruction word and, when the decoder requests it, an immediate word over a single-port instruction-memory interface with wait states. It sits between the control unit/decoder and instruction memory.

---
 rtl/pmu_pkg.sv | 18 +
 rtl/pmu_ras.sv | 119 +++++++++++
 rtl/pmu.sv | 145 ++++++++++++++
 tb/tb_pmu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared types and constants for the program management unit.
package pmu_pkg;

  // Instruction-fetch FSM states.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH_IR  = 2'd1,
    S_FETCH_IMM = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  // pc_op encodings driven by the control unit.
  localparam logic [1:0] PC_NONE   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_CALL   = 2'b10;
  localparam logic [1:0] PC_RET    = 2'b11;

endpackage

// File: rtl/pmu_ras.sv
// Return-address stack. Behaviour on overflow/underflow depends on the
// PMU_RAS_CHECK_EN macro: defined -> bad pushes/pops are dropped and flagged
// in sticky flags; undefined -> the stack is circular and the flags read 0.
module pmu_ras #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          din,
  output logic [AW-1:0]          top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   can_pop,
  output logic                   ovf,
  output logic                   udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d, sp_dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;

  assign sp_dec = sp_q - 1'b1;
  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  // Entry a pop would return right now; the top level masks it when empty.
  assign top    = mem_q[sp_dec];

`ifdef PMU_RAS_CHECK_EN
  assign can_pop = !empty;
`else
  assign can_pop = 1'b1;
`endif

  // Pointer/count next-state for push and pop.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    sp_d  = sp_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (push) begin
`ifdef PMU_RAS_CHECK_EN
      if (!full) begin
        wr_en = 1'b1;
        sp_d  = sp_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
`else
      wr_en = 1'b1;
      sp_d  = sp_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
`endif
    end else if (pop) begin
`ifdef PMU_RAS_CHECK_EN
      if (!empty) begin
        sp_d  = sp_dec;
        cnt_d = cnt_q - 1'b1;
      end
`else
      sp_d = sp_dec;
      if (!empty) cnt_d = cnt_q - 1'b1;
`endif
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; pointer and count are, so stale entries never look valid.
    if (wr_en) mem_q[sp_q] <= din;
  end

`ifdef PMU_RAS_CHECK_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky error flags, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (push & full);
    udf_d = udf_q | (!push & pop & empty);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: rtl/pmu.sv
// Program management unit: PC register, return-address stack and the
// handshaked instruction/immediate fetch FSM.
// Optional build macro: PMU_RAS_CHECK_EN (checked, non-circular RAS).
module pmu
  import pmu_pkg::*;
#(
  parameter int            DW        = 16,
  parameter int            AW        = 16,
  parameter int            RAS_DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_start,
  input  logic          need_imm,
  input  logic [1:0]    pc_op,
  input  logic          cond_en,
  input  logic          cond_ok,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_ready,
  output logic [DW-1:0] IR,
  output logic [DW-1:0] ImR,
  output logic          ir_valid,
  output logic          busy,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] RA,
  output logic          ras_ovf,
  output logic          ras_udf
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] imr_q, imr_d;
  logic          ir_valid_q, ir_valid_d;

  logic                       taken;
  logic                       ras_push, ras_pop, ras_can_pop;
  logic                       ras_full, ras_empty;
  logic [AW-1:0]              ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       ras_unused;

  pmu_ras #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ras_push),
    .pop     (ras_pop),
    .din     (pc_q),
    .top     (ras_top),
    .count   (ras_count),
    .full    (ras_full),
    .empty   (ras_empty),
    .can_pop (ras_can_pop),
    .ovf     (ras_ovf),
    .udf     (ras_udf)
  );

  // Occupancy detail is not needed at this level.
  assign ras_unused = ^{ras_count, ras_full};

  assign taken = !cond_en || cond_ok;

  // FSM next state, PC/IR/ImR updates and RAS control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imr_d      = imr_q;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    imem_rd    = 1'b0;
    busy       = 1'b1;
    ir_valid_d = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // Flow-control ops apply before a fetch started in the same cycle.
        case (pc_op)
          PC_BRANCH: if (taken) pc_d = target;
          PC_CALL: begin
            if (taken) begin
              ras_push = 1'b1;
              pc_d     = target;
            end
          end
          PC_RET: begin
            ras_pop = 1'b1;
            if (ras_can_pop) pc_d = ras_top;
          end
          default: ;
        endcase
        if (fetch_start) state_d = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        imem_rd = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = need_imm ? S_FETCH_IMM : S_DONE;
        end
      end
      S_FETCH_IMM: begin
        imem_rd = 1'b1;
        if (imem_ready) begin
          imr_d   = imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  // State, PC and instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      imr_q      <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imr_q      <= imr_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign IR        = ir_q;
  assign ImR       = imr_q;
  assign ir_valid  = ir_valid_q;
  assign PC        = pc_q;
  assign RA        = ras_empty ? '0 : ras_top;

endmodule

// File: tb/tb_pmu.sv
// Self-checking bench for pmu: table-driven flow-control vectors plus
// hand-written fetch, RAS overflow/underflow, wrap and reset sequences.
// Works with or without PMU_RAS_CHECK_EN defined.
module tb_pmu;
  import pmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic        need_imm;
  logic [1:0]  pc_op;
  logic        cond_en;
  logic        cond_ok;
  logic [15:0] target;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] ir, imr, pc, ra;
  logic        ir_valid, busy, ras_ovf, ras_udf;

  int checks   = 0;
  int failures = 0;

  // Instruction memory model with programmable wait states per read.
  logic [15:0] mem [256];
  int          waits = 0;
  int          wcnt  = 0;

  assign imem_rdata = mem[imem_addr[7:0]];
  assign imem_ready = imem_rd && (wcnt == waits);

  always @(posedge clk) begin
    if (imem_rd && !imem_ready) wcnt <= wcnt + 1;
    else                        wcnt <= 0;
  end

  always #5 clk = ~clk;

  pmu #(
    .DW        (16),
    .AW        (16),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_start (fetch_start),
    .need_imm    (need_imm),
    .pc_op       (pc_op),
    .cond_en     (cond_en),
    .cond_ok     (cond_ok),
    .target      (target),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .IR          (ir),
    .ImR         (imr),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .PC          (pc),
    .RA          (ra),
    .ras_ovf     (ras_ovf),
    .ras_udf     (ras_udf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fetch_start = 1'b0;
    need_imm    = 1'b0;
    pc_op       = PC_NONE;
    cond_en     = 1'b0;
    cond_ok     = 1'b0;
    target      = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // One IDLE cycle carrying a flow-control op.
  task automatic idle_op(input logic [1:0] op, input logic ce, input logic ok,
                         input logic [15:0] tgt);
    pc_op   = op;
    cond_en = ce;
    cond_ok = ok;
    target  = tgt;
    tick();
    pc_op   = PC_NONE;
    cond_en = 1'b0;
    cond_ok = 1'b0;
  endtask

  // Runs one fetch; lat counts edges from the start edge until ir_valid is seen,
  // moves counts address changes while a read was stalled.
  task automatic fetch(input logic need, input logic [1:0] sop, input logic [15:0] stgt,
                       input bit busy_br, output int lat, output int moves);
    logic [15:0] prev_addr;
    bit          prev_wait;
    need_imm    = need;
    pc_op       = sop;
    target      = stgt;
    cond_en     = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    pc_op       = PC_NONE;
    if (busy_br) begin
      pc_op  = PC_BRANCH;
      target = 16'h0080;
    end
    lat       = 1;
    moves     = 0;
    prev_wait = 1'b0;
    prev_addr = imem_addr;
    while (!ir_valid && lat < 40) begin
      if (prev_wait && imem_rd && imem_addr != prev_addr) moves++;
      prev_wait = imem_rd && !imem_ready;
      prev_addr = imem_addr;
      tick();
      lat++;
    end
    pc_op = PC_NONE;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        ce;
    logic        ok;
    logic [15:0] tgt;
    logic [15:0] exp_pc;
    logic [15:0] exp_ra;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] exp_ret [6];
  logic [15:0] exp_ra5;
  logic        exp_flag;

  initial begin
    int lat, moves;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h1234;
    mem[8'h05] = 16'hA001;
    mem[8'h06] = 16'h00FF;
    mem[8'h07] = 16'h5A5A;
    mem[8'h20] = 16'hBEEF;
    mem[8'h30] = 16'hCAFE;
    mem[8'h31] = 16'hD00D;
    mem[8'hFF] = 16'h7777;

    vecs[0] = '{PC_BRANCH, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000};
    vecs[1] = '{PC_BRANCH, 1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0000};
    vecs[2] = '{PC_BRANCH, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h0000};
    vecs[3] = '{PC_CALL,   1'b1, 1'b0, 16'h0100, 16'h0003, 16'h0000};
    vecs[4] = '{PC_CALL,   1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0003};
    vecs[5] = '{PC_NONE,   1'b0, 1'b0, 16'h0555, 16'h0100, 16'h0003};
    vecs[6] = '{PC_RET,    1'b0, 1'b0, 16'h0777, 16'h0003, 16'h0000};

`ifdef PMU_RAS_CHECK_EN
    exp_ret  = '{16'h0041, 16'h0031, 16'h0021, 16'h0011, 16'h0011, 16'h0011};
    exp_ra5  = 16'h0041;
    exp_flag = 1'b1;
`else
    exp_ret  = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0051, 16'h0041};
    exp_ra5  = 16'h0051;
    exp_flag = 1'b0;
`endif

    // Reset state.
    do_reset();
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_imr", imr, 16'h0000);
    check("rst_ra", ra, 16'h0000);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_imem_rd", imem_rd, 1'b0);
    check("rst_ovf", ras_ovf, 1'b0);
    check("rst_udf", ras_udf, 1'b0);

    // Plain fetch, no immediate, no wait states.
    waits = 0;
    fetch(1'b0, PC_NONE, 16'h0000, 1'b0, lat, moves);
    check("f1_latency", lat, 3);
    check("f1_ir", ir, 16'h1234);
    check("f1_pc", pc, 16'h0001);
    check("f1_imr", imr, 16'h0000);

    // Fetch with immediate at PC=5, two wait states per read.
    idle_op(PC_BRANCH, 1'b0, 1'b0, 16'h0005);
    check("f2_pc_before", pc, 16'h0005);
    waits = 2;
    fetch(1'b1, PC_NONE, 16'h0000, 1'b0, lat, moves);
    check("f2_latency", lat, 8);
    check("f2_ir", ir, 16'hA001);
    check("f2_imr", imr, 16'h00FF);
    check("f2_pc", pc, 16'h0007);
    check("f2_addr_stable", moves, 0);

    // Branch presented while busy is ignored.
    fetch(1'b0, PC_NONE, 16'h0000, 1'b1, lat, moves);
    check("f3_latency", lat, 5);
    check("f3_ir", ir, 16'h5A5A);
    check("f3_pc_busy_branch_ignored", pc, 16'h0008);
    tick();
    check("f3_ir_valid_one_cycle", ir_valid, 1'b0);

    // Branch and fetch_start together: fetch uses the new PC.
    waits = 0;
    fetch(1'b0, PC_BRANCH, 16'h0020, 1'b0, lat, moves);
    check("f4_ir", ir, 16'hBEEF);
    check("f4_pc", pc, 16'h0021);

    // Table-driven flow-control vectors.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle_op(vecs[i].op, vecs[i].ce, vecs[i].ok, vecs[i].tgt);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_ra", i), ra, vecs[i].exp_ra);
    end

    // Five calls into a 4-deep stack, then six returns.
    do_reset();
    idle_op(PC_BRANCH, 1'b0, 1'b0, 16'h0011);
    for (int k = 0; k < 5; k++) begin
      logic [15:0] tgt;
      tgt = 16'h0021 + 16'(k * 16);
      idle_op(PC_CALL, 1'b0, 1'b0, tgt);
    end
    check("ras_calls_pc", pc, 16'h0061);
    check("ras_calls_ra", ra, exp_ra5);
    check("ras_ovf", ras_ovf, exp_flag);
    for (int k = 0; k < 6; k++) begin
      idle_op(PC_RET, 1'b0, 1'b0, 16'h0000);
      check($sformatf("ras_ret%0d_pc", k + 1), pc, exp_ret[k]);
      if (k == 3) check("ras_ra_empty", ra, 16'h0000);
    end
    check("ras_udf", ras_udf, exp_flag);
    check("ras_ovf_sticky", ras_ovf, exp_flag);

    // PC wraps from all-ones to zero.
    do_reset();
    idle_op(PC_BRANCH, 1'b0, 1'b0, 16'hFFFF);
    fetch(1'b0, PC_NONE, 16'h0000, 1'b0, lat, moves);
    check("wrap_ir", ir, 16'h7777);
    check("wrap_pc", pc, 16'h0000);

    // Reset asserted during FETCH_IMM.
    do_reset();
    idle_op(PC_BRANCH, 1'b0, 1'b0, 16'h002F);
    idle_op(PC_CALL, 1'b0, 1'b0, 16'h0030);
    check("mid_ra", ra, 16'h002F);
    waits       = 3;
    need_imm    = 1'b1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 20 && imem_addr != 16'h0031; i++) tick();
    check("mid_in_fetch_imm", imem_addr, 16'h0031);
    check("mid_ir_captured", ir, 16'hCAFE);
    rst_n = 1'b0;
    tick();
    check("mid_rst_pc", pc, 16'h0000);
    check("mid_rst_ir", ir, 16'h0000);
    check("mid_rst_imr", imr, 16'h0000);
    check("mid_rst_ra", ra, 16'h0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_imem_rd", imem_rd, 1'b0);
    check("mid_rst_ir_valid", ir_valid, 1'b0);
    check("mid_rst_ovf", ras_ovf, 1'b0);
    check("mid_rst_udf", ras_udf, 1'b0);
    rst_n    = 1'b1;
    need_imm = 1'b0;
    waits    = 0;
    tick();
    check("post_rst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
